// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
//   Bundles the receiver's serial input and its word-delivery outputs.
//   Build macro: UART_RX_BREAK_DETECT_EN adds the po_break signal.
//
//   Signals:
//     rx             serial line, idle high, driven by the line side
//     po_data        received word, LSB first on the line
//     po_flag        one-cycle pulse: po_data and the error flags are valid
//     po_parity_err  parity mismatch on this word (valid with po_flag)
//     po_frame_err   a stop bit was sampled as 0 (valid with po_flag)
//     busy           a frame is in progress
//     po_break       break condition (only with UART_RX_BREAK_DETECT_EN)
//
//   Modports:
//     master  the receiver (consumes rx, drives the results)
//     slave   the line/consumer side (drives rx, observes the results)
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] po_data;
  logic                 po_flag;
  logic                 po_parity_err;
  logic                 po_frame_err;
  logic                 busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 po_break;
`endif

  modport master (
    input  rx,
    output po_data,
    output po_flag,
    output po_parity_err,
    output po_frame_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output po_break,
`endif
    output busy
  );

  modport slave (
    output rx,
    input  po_data,
    input  po_flag,
    input  po_parity_err,
    input  po_frame_err,
`ifdef UART_RX_BREAK_DETECT_EN
    input  po_break,
`endif
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver: DATA_BITS data bits (5..9), PARITY
//   (0 none, 1 odd, 2 even), STOP_BITS (1 or 2). Each bit is sampled with
//   16x oversampling and a 2-of-3 majority vote on oversample ticks 7, 8, 9.
//   Parity and framing errors are reported with every received word.
//   Build macro: UART_RX_BREAK_DETECT_EN enables break detection (po_break)
//   and a 16-tick idle-high requirement before the next frame is accepted.
//
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active-high
//     bus  uart_rx_param_if.master: rx in; po_data, po_flag,
//          po_parity_err, po_frame_err, busy (and po_break) out
module uart_rx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OSR_DIV   = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_param_if.master bus
);

  localparam int              TW        = $clog2(OSR_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(OSR_DIV - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser (rx_p0, rx_p1) and edge-detect delay (rx_p2)
  logic rx_p0, rx_p1, rx_p2;
  // arm_sr/armed: only accept a falling edge once the synchroniser holds
  // real line values and the line has been seen high, so a line held low
  // through reset does not start a frame.
  logic [1:0] arm_sr;
  logic       armed;

  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [3:0]           s_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_idx;
  logic                 perr, ferr;
  logic                 vote_a, vote_b;
  logic [DATA_BITS-1:0] shreg;

  logic [DATA_BITS-1:0] data_q;
  logic                 flag_q, perr_q, ferr_q;

  logic run, tick, resolve, wrap, fall, bit_val, exp_par, last_stop, start_ok;

`ifdef UART_RX_BREAK_DETECT_EN
  logic       par_bit;
  logic       brk_q;
  logic       brk_wait;
  logic [3:0] hcnt;
  logic       is_break;
  assign run      = (state != S_IDLE) || brk_wait;
  assign start_ok = !brk_wait;
  assign is_break = (shreg == '0) && ((PARITY == 0) || !par_bit) && (ferr || !bit_val);
`else
  assign run      = (state != S_IDLE);
  assign start_ok = 1'b1;
`endif

  assign tick      = run && (tcnt == TICK_LAST);
  assign resolve   = tick && (state != S_IDLE) && (s_cnt == 4'd9);
  assign wrap      = tick && (state != S_IDLE) && (s_cnt == 4'd15);
  assign fall      = armed && rx_p2 && !rx_p1;
  assign bit_val   = majority3(vote_a, vote_b, rx_p1);
  assign exp_par   = (PARITY == 1) ? ~(^shreg) : (^shreg);
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  // Stage p0..p2: control path, counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_p2    <= 1'b1;
      arm_sr   <= 2'b00;
      armed    <= 1'b0;
      state    <= S_IDLE;
      tcnt     <= '0;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q    <= 1'b0;
      brk_wait <= 1'b0;
      hcnt     <= '0;
`endif
    end else begin
      rx_p0  <= bus.rx;
      rx_p1  <= rx_p0;
      rx_p2  <= rx_p1;
      arm_sr <= {arm_sr[0], 1'b1};
      armed  <= armed | (arm_sr[1] & rx_p1);

      // Result strobes default low so error flags only appear with po_flag
      flag_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q  <= 1'b0;
`endif

      // Tick counter held at 0 while idle so the phase aligns to the start edge
      if (!run || tcnt == TICK_LAST) tcnt <= '0;
      else                           tcnt <= tcnt + 1'b1;

      if (tick && state != S_IDLE) s_cnt <= s_cnt + 4'd1;

`ifdef UART_RX_BREAK_DETECT_EN
      // After a break, require 16 consecutive high ticks before re-arming
      if (brk_wait) begin
        if (!rx_p1) begin
          hcnt <= '0;
        end else if (tick) begin
          if (hcnt == 4'd15) begin
            brk_wait <= 1'b0;
            hcnt     <= '0;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
      end
`endif

      case (state)
        S_IDLE: begin
          if (fall && start_ok) begin
            state    <= S_START;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (resolve && bit_val) begin
            state <= S_IDLE;
            s_cnt <= '0;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (wrap) begin
            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                     bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          if (resolve && (bit_val != exp_par)) perr <= 1'b1;
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          if (resolve) begin
            if (!bit_val) ferr <= 1'b1;
            // Return mid-stop-bit to tolerate back-to-back frames
            if (last_stop) begin
              data_q <= shreg;
              flag_q <= 1'b1;
              perr_q <= perr;
              ferr_q <= ferr | ~bit_val;
              state  <= S_IDLE;
              s_cnt  <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
              brk_q    <= is_break;
              brk_wait <= is_break;
              hcnt     <= '0;
`endif
            end
          end else if (wrap) begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: vote samples and data shift register (no reset needed)
  always_ff @(posedge clk) begin
    if (tick && s_cnt == 4'd7) vote_a <= rx_p1;
    if (tick && s_cnt == 4'd8) vote_b <= rx_p1;
    if (resolve && state == S_DATA) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
    if (resolve && state == S_PARITY) par_bit <= bit_val;
`endif
  end

  assign bus.po_data       = data_q;
  assign bus.po_flag       = flag_q;
  assign bus.po_parity_err = perr_q;
  assign bus.po_frame_err  = ferr_q;
  assign bus.busy          = (state != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign bus.po_break      = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLK  = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(7)) if_b ();
  uart_rx_param_if #(.DATA_BITS(8)) if_c ();
  assign if_a.rx = rx_a;
  assign if_b.rx = rx_b;
  assign if_c.rx = rx_c;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Per-DUT pulse monitors: latch the words/flags of each po_flag pulse and
  // count pulse-shape violations (pulse > 1 clk, error flag without pulse).
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int viol_a = 0, viol_b = 0, viol_c = 0;
  logic [7:0] last_a = '0, prev_a = '0, last_c = '0;
  logic [6:0] last_b = '0;
  logic perr_a = 0, ferr_a = 0, perr_b = 0, ferr_b = 0, perr_c = 0, ferr_c = 0;
  logic fd_a = 0, fd_b = 0, fd_c = 0;
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_a = 0;
`endif

  always @(negedge clk) begin
    if (if_a.po_flag) begin
      cnt_a++; prev_a = last_a; last_a = if_a.po_data;
      perr_a = if_a.po_parity_err; ferr_a = if_a.po_frame_err;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_a = if_a.po_break;
`endif
    end
    if (!if_a.po_flag && (if_a.po_parity_err || if_a.po_frame_err)) viol_a++;
    if (if_a.po_flag && fd_a) viol_a++;
    fd_a = if_a.po_flag;
  end

  always @(negedge clk) begin
    if (if_b.po_flag) begin
      cnt_b++; last_b = if_b.po_data;
      perr_b = if_b.po_parity_err; ferr_b = if_b.po_frame_err;
    end
    if (!if_b.po_flag && (if_b.po_parity_err || if_b.po_frame_err)) viol_b++;
    if (if_b.po_flag && fd_b) viol_b++;
    fd_b = if_b.po_flag;
  end

  always @(negedge clk) begin
    if (if_c.po_flag) begin
      cnt_c++; last_c = if_c.po_data;
      perr_c = if_c.po_parity_err; ferr_c = if_c.po_frame_err;
    end
    if (!if_c.po_flag && (if_c.po_parity_err || if_c.po_frame_err)) viol_c++;
    if (if_c.po_flag && fd_c) viol_c++;
    fd_c = if_c.po_flag;
  end

  task automatic drive(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drive clocks [t0, t1) of a frame; bit i occupies clocks i*160..i*160+159.
  // glitch_idx selects a bit that gets a 10-clk low spike at clocks 85..94.
  task automatic send_span(input int which, input logic [15:0] bits,
                           input int t0, input int t1, input int glitch_idx);
    logic v;
    int   b, c;
    for (int t = t0; t < t1; t++) begin
      b = t / BIT_CLK;
      c = t % BIT_CLK;
      v = bits[b];
      if (b == glitch_idx && c >= 85 && c < 95) v = 1'b0;
      drive(which, v);
      @(posedge clk);
    end
    drive(which, 1'b1);
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'h3F, 1'b1, d, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if_a.po_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %0h expected 0", if_a.po_data); end else passed++;
    checks++; if (if_a.po_flag !== 1'b0) begin fails++; $display("FAIL reset_flag: got %0b expected 0", if_a.po_flag); end else passed++;
    checks++; if ({if_a.busy, if_b.busy, if_c.busy} !== 3'b000) begin fails++; $display("FAIL reset_busy: got %0b expected 000", {if_a.busy, if_b.busy, if_c.busy}); end else passed++;
    checks++; if ({if_a.po_parity_err, if_a.po_frame_err} !== 2'b00) begin fails++; $display("FAIL reset_errs: got %0b expected 00", {if_a.po_parity_err, if_a.po_frame_err}); end else passed++;
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int c0, run, gap;
    bit seen;
    c0 = cnt_a; run = 0; gap = -1; seen = 0;
    fork
      begin
        send_span(0, f8n1(8'h55), 0, 10 * BIT_CLK, -1);
        send_span(0, f8n1(8'hA3), 0, 10 * BIT_CLK, -1);
      end
      begin
        repeat (20 * BIT_CLK) begin
          @(negedge clk);
          if (if_a.busy) begin
            if (seen && run > 0) gap = run;
            seen = 1; run = 0;
          end else run++;
        end
      end
    join
    repeat (50) @(posedge clk);
    checks++; if (cnt_a - c0 !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", cnt_a - c0); end else passed++;
    checks++; if (prev_a !== 8'h55) begin fails++; $display("FAIL b2b_first: got %0h expected 55", prev_a); end else passed++;
    checks++; if (last_a !== 8'hA3) begin fails++; $display("FAIL b2b_second: got %0h expected a3", last_a); end else passed++;
    checks++; if ({perr_a, ferr_a} !== 2'b00) begin fails++; $display("FAIL b2b_errs: got %0b expected 00", {perr_a, ferr_a}); end else passed++;
    checks++; if (!(gap > 0 && gap <= 90)) begin fails++; $display("FAIL b2b_gap: got %0d expected 1..90", gap); end else passed++;
  endtask

  task automatic test_parity();
    int c0;
    c0 = cnt_b;
    // 0x35 has four ones: even parity bit is 0
    send_span(1, {6'h3F, 1'b1, 1'b0, 7'h35, 1'b0}, 0, 10 * BIT_CLK, -1);
    repeat (50) @(posedge clk);
    checks++; if (last_b !== 7'h35) begin fails++; $display("FAIL par_ok_data: got %0h expected 35", last_b); end else passed++;
    checks++; if (perr_b !== 1'b0) begin fails++; $display("FAIL par_ok_perr: got %0b expected 0", perr_b); end else passed++;
    send_span(1, {6'h3F, 1'b1, 1'b1, 7'h35, 1'b0}, 0, 10 * BIT_CLK, -1);
    repeat (50) @(posedge clk);
    checks++; if (perr_b !== 1'b1) begin fails++; $display("FAIL par_bad_perr: got %0b expected 1", perr_b); end else passed++;
    checks++; if ({last_b, ferr_b} !== {7'h35, 1'b0}) begin fails++; $display("FAIL par_bad_data: got %0h/%0b expected 35/0", last_b, ferr_b); end else passed++;
    checks++; if (cnt_b - c0 !== 2) begin fails++; $display("FAIL par_pulses: got %0d expected 2", cnt_b - c0); end else passed++;
  endtask

  task automatic test_two_stop();
    int c0;
    c0 = cnt_c;
    send_span(2, {5'h1F, 1'b0, 1'b1, 8'h0F, 1'b0}, 0, 11 * BIT_CLK, -1);
    repeat (200) @(posedge clk);
    checks++; if (cnt_c - c0 !== 1) begin fails++; $display("FAIL stop2_pulses: got %0d expected 1", cnt_c - c0); end else passed++;
    checks++; if (ferr_c !== 1'b1) begin fails++; $display("FAIL stop2_ferr: got %0b expected 1", ferr_c); end else passed++;
    checks++; if (last_c !== 8'h0F) begin fails++; $display("FAIL stop2_data: got %0h expected 0f", last_c); end else passed++;
    send_span(2, {5'h1F, 1'b1, 1'b1, 8'hC3, 1'b0}, 0, 11 * BIT_CLK, -1);
    repeat (50) @(posedge clk);
    checks++; if ({last_c, ferr_c, perr_c} !== {8'hC3, 2'b00}) begin fails++; $display("FAIL stop2_good: got %0h/%0b/%0b expected c3/0/0", last_c, ferr_c, perr_c); end else passed++;
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cnt_a;
    rx_a = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++; if (if_a.busy !== 1'b1) begin fails++; $display("FAIL glitch_start_busy: got %0b expected 1", if_a.busy); end else passed++;
    repeat (20) @(posedge clk);
    rx_a = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_after: got %0b expected 0", if_a.busy); end else passed++;
    checks++; if (cnt_a - c0 !== 0) begin fails++; $display("FAIL glitch_no_pulse: got %0d expected 0", cnt_a - c0); end else passed++;
    // Spike on data bit 3 (frame index 4) around its s_cnt=8 sample
    send_span(0, f8n1(8'hFF), 0, 10 * BIT_CLK, 4);
    repeat (50) @(posedge clk);
    checks++; if ({last_a, ferr_a} !== {8'hFF, 1'b0}) begin fails++; $display("FAIL glitch_spike_data: got %0h/%0b expected ff/0", last_a, ferr_a); end else passed++;
  endtask

  task automatic test_reset_midframe();
    int c0;
    c0 = cnt_a;
    // 0x81: data bit 4 (frame index 5) is 0, so the line is low through reset
    send_span(0, f8n1(8'h81), 0, 5 * BIT_CLK + 80, -1);
    rx_a = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({if_a.po_data, if_a.po_flag, if_a.busy, if_a.po_frame_err} !== 11'b0) begin fails++; $display("FAIL midrst_outputs: got %0h expected 0", {if_a.po_data, if_a.po_flag, if_a.busy, if_a.po_frame_err}); end else passed++;
    rst = 1'b0;
    send_span(0, f8n1(8'h81), 5 * BIT_CLK + 81, 10 * BIT_CLK, -1);
    repeat (300) @(posedge clk);
    checks++; if (cnt_a - c0 !== 0) begin fails++; $display("FAIL midrst_no_pulse: got %0d expected 0", cnt_a - c0); end else passed++;
    send_span(0, f8n1(8'h42), 0, 10 * BIT_CLK, -1);
    repeat (50) @(posedge clk);
    checks++; if (cnt_a - c0 !== 1) begin fails++; $display("FAIL midrst_next_pulse: got %0d expected 1", cnt_a - c0); end else passed++;
    checks++; if (last_a !== 8'h42) begin fails++; $display("FAIL midrst_next_data: got %0h expected 42", last_a); end else passed++;
  endtask

  task automatic test_break();
    int c0;
    c0 = cnt_a;
    rx_a = 1'b0;
    repeat (20 * BIT_CLK) @(posedge clk);
    rx_a = 1'b1;
    repeat (50) @(posedge clk);
    checks++; if (cnt_a - c0 !== 1) begin fails++; $display("FAIL brk_pulses: got %0d expected 1", cnt_a - c0); end else passed++;
    checks++; if ({last_a, ferr_a} !== {8'h00, 1'b1}) begin fails++; $display("FAIL brk_word: got %0h/%0b expected 0/1", last_a, ferr_a); end else passed++;
`ifdef UART_RX_BREAK_DETECT_EN
    checks++; if (brk_a !== 1'b1) begin fails++; $display("FAIL brk_flag: got %0b expected 1", brk_a); end else passed++;
    // Only 5 idle ticks so far: a falling edge must be ignored
    rx_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("FAIL brk_ignore_edge: got %0b expected 0", if_a.busy); end else passed++;
    repeat (10) @(posedge clk);
    rx_a = 1'b1;
`endif
    repeat (300) @(posedge clk);
    send_span(0, f8n1(8'h7E), 0, 10 * BIT_CLK, -1);
    repeat (50) @(posedge clk);
    checks++; if ({last_a, ferr_a} !== {8'h7E, 1'b0}) begin fails++; $display("FAIL brk_next_data: got %0h/%0b expected 7e/0", last_a, ferr_a); end else passed++;
    checks++; if (cnt_a - c0 !== 2) begin fails++; $display("FAIL brk_next_pulses: got %0d expected 2", cnt_a - c0); end else passed++;
`ifdef UART_RX_BREAK_DETECT_EN
    checks++; if (brk_a !== 1'b0) begin fails++; $display("FAIL brk_next_flag: got %0b expected 0", brk_a); end else passed++;
`endif
  endtask

  task automatic test_flag_shape();
    checks++; if (viol_a + viol_b + viol_c !== 0) begin fails++; $display("FAIL flag_shape: got %0d violations expected 0", viol_a + viol_b + viol_c); end else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_glitch();
    test_reset_midframe();
    test_break();
    test_flag_shape();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
